// File: rtl/spmv_pe_mem_port.sv
// ---------------------------------------------------------------------------
// spmv_pe_mem_port
//
// Memory-side responder for one spmv_pe memory port. Load/store requests from
// the PE are queued in a request FIFO and issued in strict order onto one
// Convey MC port. Load data coming back from the MC (in any order) is queued
// in a response FIFO and handed to the PE through a registered output stage.
// Outstanding-load credits cap in-flight loads at RSP_DEPTH so the response
// FIFO can never overflow. A small RUN/DRAIN/DONE FSM implements the flush
// handshake used by control logic to confirm all PE traffic has drained.
//
// Parameters
//   REQ_DEPTH  request FIFO entries (power of two, >= 8)
//   RSP_DEPTH  response FIFO entries (power of two) and max outstanding loads
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_mem_ld/st/addr/d_or_tag   PE request (tag in d_or_tag[2:0] for loads)
//   req_mem_stall                 back-pressure to the PE
//   rsp_mem_push/tag/q            load data to the PE
//   rsp_mem_stall                 PE cannot accept a response
//   mc_req_ld/st/vadr/wrd_rdctl   registered MC request
//   mc_rd_rq_stall/wr_rq_stall    MC request back-pressure
//   mc_rsp_push/wr/rdctl/data     MC response (write completion or read data)
//   mc_rsp_stall                  back-pressure to the MC (response FIFO full)
//   flush_req/flush_done          drain handshake
//   busy                          some request or response still pending
//   err_overflow                  sticky: request dropped or ld+st together
//
// Optional feature macro: SPMV_MEM_PORT_STATS_EN adds 32-bit wrapping counters
// stat_ld, stat_st (issued loads/stores) and stat_stall (cycles stalled).
// ---------------------------------------------------------------------------
module spmv_pe_mem_port #(
    parameter int REQ_DEPTH = 16,
    parameter int RSP_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_mem_ld,
    input  logic        req_mem_st,
    input  logic [47:0] req_mem_addr,
    input  logic [63:0] req_mem_d_or_tag,
    output logic        req_mem_stall,
    output logic        rsp_mem_push,
    output logic [2:0]  rsp_mem_tag,
    output logic [63:0] rsp_mem_q,
    input  logic        rsp_mem_stall,
    output logic        mc_req_ld,
    output logic        mc_req_st,
    output logic [47:0] mc_req_vadr,
    output logic [63:0] mc_req_wrd_rdctl,
    input  logic        mc_rd_rq_stall,
    input  logic        mc_wr_rq_stall,
    input  logic        mc_rsp_push,
    input  logic        mc_rsp_wr,
    input  logic [2:0]  mc_rsp_rdctl,
    input  logic [63:0] mc_rsp_data,
    output logic        mc_rsp_stall,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        busy,
`ifdef SPMV_MEM_PORT_STATS_EN
    output logic [31:0] stat_ld,
    output logic [31:0] stat_st,
    output logic [31:0] stat_stall,
`endif
    output logic        err_overflow
);

    localparam int RQAW = $clog2(REQ_DEPTH);
    localparam int RSAW = $clog2(RSP_DEPTH);
    localparam int RQCW = RQAW + 1;
    localparam int RSCW = RSAW + 1;
    localparam logic [RQCW-1:0] REQ_FULL_LVL  = RQCW'(REQ_DEPTH);
    // Margin of 3 covers the PE's 2-cycle pop-to-request pipeline plus slack.
    localparam logic [RQCW-1:0] REQ_STALL_LVL = RQCW'(REQ_DEPTH - 3);
    localparam logic [RSCW-1:0] RSP_FULL_LVL  = RSCW'(RSP_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

    state_e            state_q, state_d;
    logic [112:0]      req_fifo [REQ_DEPTH];
    logic [RQAW-1:0]   req_wptr_q, req_rptr_q;
    logic [RQCW-1:0]   req_cnt_q, req_cnt_d;
    logic [66:0]       rsp_fifo [RSP_DEPTH];
    logic [RSAW-1:0]   rsp_wptr_q, rsp_rptr_q;
    logic [RSCW-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic [RSCW-1:0]   ld_out_q, ld_out_d, st_out_q, st_out_d;
    logic              rsp_push_q;
    logic [2:0]        rsp_tag_q;
    logic [63:0]       rsp_q_q;
    logic              mc_ld_q, mc_st_q;
    logic [47:0]       mc_vadr_q;
    logic [63:0]       mc_wrd_q;
    logic              err_q;

    logic              req_in, req_full, req_empty, req_push, req_pop;
    logic              ld_issue, st_issue, head_st;
    logic [112:0]      head;
    logic              rsp_full, rsp_empty, rsp_push, rsp_pop, wr_ack, drained;

    assign req_in    = req_mem_ld | req_mem_st;
    assign req_full  = (req_cnt_q == REQ_FULL_LVL);
    assign req_empty = (req_cnt_q == '0);
    assign req_push  = req_in && !req_full;
    assign head      = req_fifo[req_rptr_q];
    assign head_st   = head[112];
    // A load needs a free credit so its read data always has a response slot.
    assign ld_issue  = !req_empty && !head_st && !mc_rd_rq_stall && (ld_out_q < RSP_FULL_LVL);
    assign st_issue  = !req_empty && head_st && !mc_wr_rq_stall;
    assign req_pop   = ld_issue | st_issue;

    assign rsp_full  = (rsp_cnt_q == RSP_FULL_LVL);
    assign rsp_empty = (rsp_cnt_q == '0);
    assign rsp_push  = mc_rsp_push && !mc_rsp_wr && !rsp_full;
    assign rsp_pop   = !rsp_empty && !rsp_mem_stall;
    assign wr_ack    = mc_rsp_push && mc_rsp_wr;
    assign drained   = req_empty && (ld_out_q == '0) && (st_out_q == '0) && rsp_empty && !rsp_push_q;

    assign req_mem_stall    = (req_cnt_q >= REQ_STALL_LVL) || (state_q != ST_RUN);
    assign flush_done       = (state_q == ST_DONE);
    assign busy             = !drained;
    assign mc_rsp_stall     = rsp_full;
    assign rsp_mem_push     = rsp_push_q;
    assign rsp_mem_tag      = rsp_tag_q;
    assign rsp_mem_q        = rsp_q_q;
    assign mc_req_ld        = mc_ld_q;
    assign mc_req_st        = mc_st_q;
    assign mc_req_vadr      = mc_vadr_q;
    assign mc_req_wrd_rdctl = mc_wrd_q;
    assign err_overflow     = err_q;

    // Occupancy and outstanding counters; simultaneous inc/dec cancel out.
    always_comb begin
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        ld_out_d  = ld_out_q;
        st_out_d  = st_out_q;
        if (req_push && !req_pop)      req_cnt_d = req_cnt_q + RQCW'(1);
        else if (!req_push && req_pop) req_cnt_d = req_cnt_q - RQCW'(1);
        if (rsp_push && !rsp_pop)      rsp_cnt_d = rsp_cnt_q + RSCW'(1);
        else if (!rsp_push && rsp_pop) rsp_cnt_d = rsp_cnt_q - RSCW'(1);
        if (ld_issue && !rsp_pop)      ld_out_d  = ld_out_q + RSCW'(1);
        else if (!ld_issue && rsp_pop) ld_out_d  = ld_out_q - RSCW'(1);
        if (st_issue && !wr_ack)       st_out_d  = st_out_q + RSCW'(1);
        else if (!st_issue && wr_ack)  st_out_d  = st_out_q - RSCW'(1);
    end

    // Flush FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_req)  state_d = ST_DRAIN;
            ST_DRAIN: if (drained)    state_d = ST_DONE;
            ST_DONE:  if (!flush_req) state_d = ST_RUN;
            default:                  state_d = ST_RUN;
        endcase
    end

    // FIFO storage needs no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (req_push) req_fifo[req_wptr_q] <= {req_mem_st, req_mem_addr, req_mem_d_or_tag};
        if (rsp_push) rsp_fifo[rsp_wptr_q] <= {mc_rsp_rdctl, mc_rsp_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            req_wptr_q <= '0;
            req_rptr_q <= '0;
            req_cnt_q  <= '0;
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            rsp_cnt_q  <= '0;
            ld_out_q   <= '0;
            st_out_q   <= '0;
            rsp_push_q <= 1'b0;
            rsp_tag_q  <= '0;
            rsp_q_q    <= '0;
            mc_ld_q    <= 1'b0;
            mc_st_q    <= 1'b0;
            mc_vadr_q  <= '0;
            mc_wrd_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            ld_out_q   <= ld_out_d;
            st_out_q   <= st_out_d;
            if (req_push) req_wptr_q <= req_wptr_q + RQAW'(1);
            if (req_pop)  req_rptr_q <= req_rptr_q + RQAW'(1);
            if (rsp_push) rsp_wptr_q <= rsp_wptr_q + RSAW'(1);
            if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + RSAW'(1);
            rsp_push_q <= rsp_pop;
            if (rsp_pop) begin
                rsp_tag_q <= rsp_fifo[rsp_rptr_q][66:64];
                rsp_q_q   <= rsp_fifo[rsp_rptr_q][63:0];
            end
            mc_ld_q <= ld_issue;
            mc_st_q <= st_issue;
            if (req_pop) begin
                mc_vadr_q <= head[111:64];
                mc_wrd_q  <= head_st ? head[63:0] : {61'b0, head[2:0]};
            end
            if ((req_mem_ld && req_mem_st) || (req_in && req_full)) err_q <= 1'b1;
        end
    end

`ifdef SPMV_MEM_PORT_STATS_EN
    logic [31:0] stat_ld_q, stat_st_q, stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ld_q    <= '0;
            stat_st_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (ld_issue)      stat_ld_q    <= stat_ld_q + 32'd1;
            if (st_issue)      stat_st_q    <= stat_st_q + 32'd1;
            if (req_mem_stall) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_ld    = stat_ld_q;
    assign stat_st    = stat_st_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_spmv_pe_mem_port.sv
// ---------------------------------------------------------------------------
// tb_spmv_pe_mem_port
//
// Directed + randomized bench for spmv_pe_mem_port. A negedge monitor records
// every MC request and every PE response into queues; the reference model is
// simply the ordered list of requests the PE made (mapped to MC format) and
// the ordered list of read responses the MC returned.
// ---------------------------------------------------------------------------
module tb_spmv_pe_mem_port;
    localparam int REQ_DEPTH = 16;
    localparam int RSP_DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_mem_ld, req_mem_st;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic        req_mem_stall;
    logic        rsp_mem_push;
    logic [2:0]  rsp_mem_tag;
    logic [63:0] rsp_mem_q;
    logic        rsp_mem_stall;
    logic        mc_req_ld, mc_req_st;
    logic [47:0] mc_req_vadr;
    logic [63:0] mc_req_wrd_rdctl;
    logic        mc_rd_rq_stall, mc_wr_rq_stall;
    logic        mc_rsp_push, mc_rsp_wr;
    logic [2:0]  mc_rsp_rdctl;
    logic [63:0] mc_rsp_data;
    logic        mc_rsp_stall;
    logic        flush_req, flush_done, busy, err_overflow;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [112:0] expMc[$];
    logic [112:0] gotMc[$];
    logic [66:0]  expRsp[$];
    logic [66:0]  gotRsp[$];
    int           ldCycles[$];
    int           rspCycles[$];

    always #5 clk = ~clk;

    spmv_pe_mem_port #(.REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st),
        .req_mem_addr(req_mem_addr), .req_mem_d_or_tag(req_mem_d_or_tag),
        .req_mem_stall(req_mem_stall),
        .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
        .rsp_mem_stall(rsp_mem_stall),
        .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st),
        .mc_req_vadr(mc_req_vadr), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
        .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
        .mc_rsp_push(mc_rsp_push), .mc_rsp_wr(mc_rsp_wr),
        .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data),
        .mc_rsp_stall(mc_rsp_stall),
        .flush_req(flush_req), .flush_done(flush_done),
        .busy(busy), .err_overflow(err_overflow)
    );

    // Monitor: sample DUT outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (mc_req_ld || mc_req_st) gotMc.push_back({mc_req_st, mc_req_vadr, mc_req_wrd_rdctl});
        if (mc_req_ld) ldCycles.push_back(cycle);
        if (rsp_mem_push) begin
            gotRsp.push_back({rsp_mem_tag, rsp_mem_q});
            rspCycles.push_back(cycle);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What the MC should see for a PE request: stores carry data, loads carry the tag only.
    function automatic logic [112:0] expEntry(input bit st, input logic [47:0] a, input logic [63:0] d);
        return {st, a, st ? d : {61'b0, d[2:0]}};
    endfunction

    task automatic applyStimulus(input bit ld, input bit st, input logic [47:0] a, input logic [63:0] d);
        req_mem_ld = ld;
        req_mem_st = st;
        req_mem_addr = a;
        req_mem_d_or_tag = d;
        tick();
        req_mem_ld = 1'b0;
        req_mem_st = 1'b0;
    endtask

    // PE model: keeps sending while not stalled, and for two cycles after stall is seen.
    task automatic peSend(input int n, input bit isSt, input int maxCyc, input bit chkStall, output int sent);
        int hi;
        logic [47:0] a;
        logic [63:0] d;
        hi = 0;
        sent = 0;
        for (int c = 0; c < maxCyc && sent < n; c++) begin
            if (chkStall)
                checkOutput("stall_level", 128'(req_mem_stall), 128'(sent >= REQ_DEPTH - 3));
            hi = req_mem_stall ? hi + 1 : 0;
            if (hi <= 2) begin
                a = 48'({$urandom, $urandom});
                d = {$urandom, $urandom};
                req_mem_ld = !isSt;
                req_mem_st = isSt;
                req_mem_addr = a;
                req_mem_d_or_tag = d;
                expMc.push_back(expEntry(isSt, a, d));
                sent++;
            end else begin
                req_mem_ld = 1'b0;
                req_mem_st = 1'b0;
            end
            tick();
        end
        req_mem_ld = 1'b0;
        req_mem_st = 1'b0;
    endtask

    task automatic mcWriteAck(input int n);
        for (int i = 0; i < n; i++) begin
            mc_rsp_push = 1'b1;
            mc_rsp_wr = 1'b1;
            tick();
        end
        mc_rsp_push = 1'b0;
        mc_rsp_wr = 1'b0;
    endtask

    task automatic mcReadRsp(input logic [2:0] tag, input logic [63:0] data);
        mc_rsp_push = 1'b1;
        mc_rsp_wr = 1'b0;
        mc_rsp_rdctl = tag;
        mc_rsp_data = data;
        expRsp.push_back({tag, data});
        tick();
        mc_rsp_push = 1'b0;
    endtask

    task automatic compareMc(input string nm);
        int guard;
        guard = 0;
        while (gotMc.size() < expMc.size() && guard < 300) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        checkOutput({nm, "_mc_count"}, 128'(gotMc.size()), 128'(expMc.size()));
        for (int i = 0; i < expMc.size() && i < gotMc.size(); i++)
            checkOutput({nm, "_mc_entry"}, 128'(gotMc[i]), 128'(expMc[i]));
        expMc.delete();
        gotMc.delete();
    endtask

    task automatic compareRsp(input string nm);
        int guard;
        guard = 0;
        while (gotRsp.size() < expRsp.size() && guard < 300) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        checkOutput({nm, "_rsp_count"}, 128'(gotRsp.size()), 128'(expRsp.size()));
        for (int i = 0; i < expRsp.size() && i < gotRsp.size(); i++)
            checkOutput({nm, "_rsp_entry"}, 128'(gotRsp[i]), 128'(expRsp[i]));
        expRsp.delete();
        gotRsp.delete();
    endtask

    task automatic checkAllZero(input string nm);
        checkOutput({nm, "_ctrl"}, 128'({req_mem_stall, rsp_mem_push, rsp_mem_tag, mc_req_ld, mc_req_st,
                                         mc_rsp_stall, flush_done, busy, err_overflow}), 128'(0));
        checkOutput({nm, "_data"}, 128'({rsp_mem_q, mc_req_wrd_rdctl}), 128'(0));
        checkOutput({nm, "_vadr"}, 128'(mc_req_vadr), 128'(0));
    endtask

    // Load at 0x1000 tag 5; MC answers 4 cycles after the request is seen.
    task automatic singleLoadTest(input string nm);
        gotMc.delete();
        gotRsp.delete();
        applyStimulus(1'b1, 1'b0, 48'h1000, 64'h5);
        checkOutput({nm, "_ld_early"}, 128'(mc_req_ld), 128'(0));
        tick();
        checkOutput({nm, "_ld"}, 128'(mc_req_ld), 128'(1));
        checkOutput({nm, "_vadr"}, 128'(mc_req_vadr), 128'(48'h1000));
        checkOutput({nm, "_rdctl"}, 128'(mc_req_wrd_rdctl), 128'(5));
        checkOutput({nm, "_busy"}, 128'(busy), 128'(1));
        tick();
        checkOutput({nm, "_ld_pulse"}, 128'(mc_req_ld), 128'(0));
        repeat (2) tick();
        mcReadRsp(3'd5, 64'hDEADBEEF);
        expRsp.delete();
        checkOutput({nm, "_push_early"}, 128'(rsp_mem_push), 128'(0));
        tick();
        checkOutput({nm, "_push"}, 128'({rsp_mem_push, rsp_mem_tag, rsp_mem_q}), 128'({1'b1, 3'd5, 64'hDEADBEEF}));
        tick();
        checkOutput({nm, "_push_pulse"}, 128'(rsp_mem_push), 128'(0));
        checkOutput({nm, "_idle"}, 128'(busy), 128'(0));
        checkOutput({nm, "_mc_total"}, 128'(gotMc.size()), 128'(1));
        gotMc.delete();
        gotRsp.delete();
    endtask

    initial begin
        int sent;
        int guard;
        int respIdx;
        bit sawMcStall;
        bit sawDone;
        logic [63:0] d;
        rst_n = 1'b0;
        req_mem_ld = 1'b0; req_mem_st = 1'b0; req_mem_addr = '0; req_mem_d_or_tag = '0;
        rsp_mem_stall = 1'b0;
        mc_rd_rq_stall = 1'b0; mc_wr_rq_stall = 1'b0;
        mc_rsp_push = 1'b0; mc_rsp_wr = 1'b0; mc_rsp_rdctl = '0; mc_rsp_data = '0;
        flush_req = 1'b0;

        // Reset state
        repeat (3) tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();
        checkAllZero("post_reset");

        $display("[TB] single load");
        singleLoadTest("load1");

        $display("[TB] store burst against MC write stall");
        mc_wr_rq_stall = 1'b1;
        peSend(20, 1'b1, 20, 1'b1, sent);
        checkOutput("burst_accepted", 128'(sent), 128'(15));
        checkOutput("burst_no_issue", 128'(gotMc.size()), 128'(0));
        checkOutput("burst_err", 128'(err_overflow), 128'(0));
        mc_wr_rq_stall = 1'b0;
        peSend(5, 1'b1, 100, 1'b0, sent);
        checkOutput("burst_rest", 128'(sent), 128'(5));
        compareMc("burst");
        mcWriteAck(20);
        tick();
        checkOutput("burst_idle", 128'({busy, err_overflow}), 128'(0));

        $display("[TB] load credits");
        ldCycles.delete();
        rspCycles.delete();
        peSend(40, 1'b0, 100, 1'b0, sent);
        repeat (10) tick();
        checkOutput("credit_cap", 128'(ldCycles.size()), 128'(RSP_DEPTH));
        mcReadRsp(3'($urandom), {$urandom, $urandom});
        guard = 0;
        while (ldCycles.size() <= RSP_DEPTH && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("credit_33rd_seen", 128'(ldCycles.size() > RSP_DEPTH), 128'(1));
        if (ldCycles.size() > RSP_DEPTH && rspCycles.size() > 0)
            checkOutput("credit_33rd_cycle", 128'(ldCycles[RSP_DEPTH]), 128'(rspCycles[0] + 1));
        respIdx = 1;
        sawMcStall = 1'b0;
        guard = 0;
        while (respIdx < 40 && guard < 400) begin
            rsp_mem_stall = ($urandom_range(0, 3) == 0);
            if (mc_rsp_stall) sawMcStall = 1'b1;
            if (respIdx < ldCycles.size() && $urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom};
                mc_rsp_push = 1'b1;
                mc_rsp_wr = 1'b0;
                mc_rsp_rdctl = 3'($urandom);
                mc_rsp_data = d;
                expRsp.push_back({mc_rsp_rdctl, d});
                respIdx++;
            end else begin
                mc_rsp_push = 1'b0;
            end
            tick();
            guard++;
        end
        mc_rsp_push = 1'b0;
        rsp_mem_stall = 1'b0;
        checkOutput("credit_mc_stall", 128'(sawMcStall), 128'(0));
        compareRsp("credit");
        compareMc("credit");
        checkOutput("credit_idle", 128'(busy), 128'(0));

        $display("[TB] out-of-order read data with PE stall");
        applyStimulus(1'b1, 1'b0, 48'h2000, 64'h1); expMc.push_back(expEntry(1'b0, 48'h2000, 64'h1));
        applyStimulus(1'b1, 1'b0, 48'h2008, 64'h2); expMc.push_back(expEntry(1'b0, 48'h2008, 64'h2));
        applyStimulus(1'b1, 1'b0, 48'h2010, 64'h3); expMc.push_back(expEntry(1'b0, 48'h2010, 64'h3));
        compareMc("ooo");
        rsp_mem_stall = 1'b1;
        mcReadRsp(3'd3, 64'h3333_0000_0000_0003);
        mcReadRsp(3'd1, 64'h1111_0000_0000_0001);
        mcReadRsp(3'd2, 64'h2222_0000_0000_0002);
        repeat (2) tick();
        checkOutput("ooo_held", 128'({rsp_mem_push, 8'(gotRsp.size())}), 128'(0));
        rsp_mem_stall = 1'b0;
        compareRsp("ooo");

        $display("[TB] flush");
        peSend(4, 1'b0, 20, 1'b0, sent);
        peSend(2, 1'b1, 20, 1'b0, sent);
        compareMc("flush");
        flush_req = 1'b1;
        tick();
        checkOutput("flush_stall", 128'({req_mem_stall, flush_done, busy}), 128'(3'b101));
        mcWriteAck(2);
        repeat (3) tick();
        checkOutput("flush_wait_ld", 128'(flush_done), 128'(0));
        for (int i = 0; i < 4; i++) mcReadRsp(3'($urandom), {$urandom, $urandom});
        sawDone = 1'b0;
        guard = 0;
        while (!sawDone && guard < 30) begin
            if (flush_done) begin
                sawDone = 1'b1;
                checkOutput("flush_after_deliv", 128'(gotRsp.size()), 128'(4));
            end else begin
                tick();
            end
            guard++;
        end
        checkOutput("flush_done", 128'(sawDone), 128'(1));
        compareRsp("flush");
        flush_req = 1'b0;
        tick();
        checkOutput("flush_release", 128'({flush_done, req_mem_stall, busy}), 128'(0));

        $display("[TB] overflow then reset mid-traffic");
        mc_wr_rq_stall = 1'b1;
        for (int i = 0; i < REQ_DEPTH + 1; i++)
            applyStimulus(1'b0, 1'b1, 48'($urandom), {$urandom, $urandom});
        checkOutput("ovf_err", 128'({err_overflow, req_mem_stall, busy}), 128'(3'b111));
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        tick();
        rst_n = 1'b1;
        mc_wr_rq_stall = 1'b0;
        tick();
        checkOutput("midreset_clean", 128'({busy, err_overflow, mc_req_st}), 128'(0));
        expMc.delete();
        gotMc.delete();
        singleLoadTest("load2");

        $display("[TB] simultaneous ld+st");
        d = {$urandom, $urandom};
        applyStimulus(1'b1, 1'b1, 48'hABC0, d);
        expMc.push_back(expEntry(1'b1, 48'hABC0, d));
        compareMc("ldst");
        checkOutput("ldst_err", 128'(err_overflow), 128'(1));
        mcWriteAck(1);
        tick();
        checkOutput("ldst_idle", 128'(busy), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
